// File: rtl/bg_picture_mixer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bg_mix_pkg                                                   |
// | Description : Shared types, constants and blend helper for the background  |
// |               picture mixer.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bg_mix_pkg;

   localparam int PIC_PIXELS_DEFAULT = 307200;
   localparam int PIXEL_W            = 32;
   localparam int RGB_W              = 24;

   typedef enum logic [1:0] {
      MIX_BYPASS = 2'd0,
      MIX_KEY    = 2'd1,
      MIX_ALPHA  = 2'd2,
      MIX_BG     = 2'd3
   } mix_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } pixel_t;

   // aw is the expanded alpha (0..256); the weighted sum never exceeds 255*256
   function automatic logic [7:0] blend_ch(input logic [7:0] bg,
                                           input logic [7:0] fg,
                                           input logic [8:0] aw);
      logic [16:0] acc;
      acc = ({9'd0, bg} * {8'd0, aw}) + ({9'd0, fg} * {8'd0, 9'd256 - aw});
      return acc[15:8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bg_picture_mixer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bg_mem_if                                                    |
// | Description : Read-only SDRAM channel port used by the picture fetcher.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bg_mem_if
   import bg_mix_pkg::*;
#(
   parameter int AW = 24
);
   logic [AW-1:0]      mem_addr;
   logic               mem_req;
   logic               mem_ack;
   logic [PIXEL_W-1:0] mem_dout;

   modport master (output mem_addr, output mem_req, input mem_ack, input mem_dout);
   modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_dout);
endinterface
`default_nettype wire

// File: rtl/bg_picture_mixer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bg_fifo                                                      |
// | Description : Synchronous show-ahead FIFO with flush and occupancy count.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bg_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     flush,
   input  wire logic                     push,
   input  wire logic [WIDTH-1:0]         wdata,
   input  wire logic                     pop,
   output logic      [WIDTH-1:0]         rdata,
   output logic                          empty,
   output logic      [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the count alone defines which entries are live
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/bg_picture_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bg_picture_mixer                                             |
// | Description : Prefetches an ABGR background picture from SDRAM and mixes   |
// |               it with foreground RGB, one pixel per ce_pix.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bg_picture_mixer
   import bg_mix_pkg::*;
#(
   parameter int AW         = 24,
   parameter int FIFO_DEPTH = 8,
   parameter int PIC_PIXELS = PIC_PIXELS_DEFAULT
) (
   input  wire logic              clk_sys,
   input  wire logic              reset,
   input  wire logic              ce_pix,
   input  wire logic              hblank,
   input  wire logic              vblank,
   input  wire logic              vs,
   input  wire logic              enable,
   input  wire logic [1:0]        mode,
   input  wire logic [RGB_W-1:0]  fg_rgb,
   bg_mem_if.master               mem,
   output logic      [RGB_W-1:0]  rgb_out,
   output logic                   underflow
);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W = (PIC_PIXELS > 1) ? $clog2(PIC_PIXELS) : 1;

   fetch_state_t     state_q, state_d;
   logic             discard_q, discard_d;
   logic [IDX_W-1:0] pix_q, pix_d, pix_next;
   logic [AW-1:0]    addr_q, addr_d;
   logic             vs_q, vs_d;
   logic             underflow_q, underflow_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;

   logic             restart;
   logic             flush;
   logic             pop_req;
   logic             push;
   logic             blank;
   logic             head_ok;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [PIXEL_W-1:0] fifo_head;
   pixel_t           head_px;
   logic [RGB_W-1:0] bg_rgb;
   logic [7:0]       alpha;
   logic [8:0]       alpha_w;
   logic [RGB_W-1:0] blend_rgb;
   logic [RGB_W-1:0] mix_rgb;

   assign restart  = ce_pix & vs & ~vs_q;
   assign flush    = restart | ~enable;
   assign blank    = hblank | vblank;
   assign pop_req  = ce_pix & ~blank & enable;
   assign pix_next = (pix_q == IDX_W'(PIC_PIXELS - 1)) ? '0 : pix_q + IDX_W'(1);

   bg_fifo #(
      .WIDTH (PIXEL_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_sys),
      .rst   (reset),
      .flush (flush),
      .push  (push),
      .wdata (mem.mem_dout),
      .pop   (pop_req),
      .rdata (fifo_head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Fetch FSM: one request in flight; a flush while waiting drops that reply
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      pix_d     = pix_q;
      addr_d    = addr_q;
      push      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable && (fifo_count < CW'(FIFO_DEPTH)) && !restart) begin
               state_d = ST_REQ;
               addr_d  = AW'({pix_q, 1'b0});
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
            if (flush) discard_d = 1'b1;
         end
         ST_WAIT: begin
            if (mem.mem_ack) begin
               state_d   = ST_IDLE;
               discard_d = 1'b0;
               if (!discard_q && !flush) begin
                  push  = 1'b1;
                  pix_d = pix_next;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (restart) pix_d = '0;
   end

   always_comb begin
      vs_d        = ce_pix ? vs : vs_q;
      underflow_d = underflow_q;
      if (pop_req && fifo_empty) underflow_d = 1'b1;
      if (restart)               underflow_d = 1'b0;
   end

   // Mixer: an empty FIFO or blanking presents a transparent black background
   assign head_px = pixel_t'(fifo_head);
   assign head_ok = ~fifo_empty & ~blank;
   assign bg_rgb  = head_ok ? {head_px.r, head_px.g, head_px.b} : '0;
   assign alpha   = head_ok ? head_px.a : 8'd0;
   assign alpha_w = {1'b0, alpha} + {8'd0, alpha[7]};

   generate
      for (genvar ch = 0; ch < 3; ch++) begin : g_blend
         assign blend_rgb[ch*8 +: 8] = blend_ch(bg_rgb[ch*8 +: 8], fg_rgb[ch*8 +: 8], alpha_w);
      end
   endgenerate

   always_comb begin
      mix_rgb = fg_rgb;
      if (blank) begin
         mix_rgb = '0;
      end else if (enable) begin
         unique case (mix_mode_t'(mode))
            MIX_BYPASS: mix_rgb = fg_rgb;
            MIX_KEY:    mix_rgb = ((fg_rgb != '0) && (alpha == 8'd0)) ? fg_rgb : bg_rgb;
            MIX_ALPHA:  mix_rgb = blend_rgb;
            MIX_BG:     mix_rgb = bg_rgb;
            default:    mix_rgb = fg_rgb;
         endcase
      end
      rgb_d = ce_pix ? mix_rgb : rgb_q;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         discard_q   <= 1'b0;
         pix_q       <= '0;
         addr_q      <= '0;
         vs_q        <= 1'b0;
         underflow_q <= 1'b0;
         rgb_q       <= '0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         pix_q       <= pix_d;
         addr_q      <= addr_d;
         vs_q        <= vs_d;
         underflow_q <= underflow_d;
         rgb_q       <= rgb_d;
      end
   end

   assign mem.mem_req  = (state_q == ST_REQ);
   assign mem.mem_addr = addr_q;
   assign rgb_out      = rgb_q;
   assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_picture_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bg_picture_mixer                                          |
// | Description : Scoreboard bench for bg_picture_mixer with an SDRAM model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bg_picture_mixer;
   import bg_mix_pkg::*;

   localparam int AW  = 24;
   localparam int PIC = 16;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        ce_pix  = 1'b0;
   logic        hblank  = 1'b0;
   logic        vblank  = 1'b0;
   logic        vs      = 1'b0;
   logic        enable  = 1'b0;
   logic [1:0]  mode    = 2'd0;
   logic [23:0] fg_rgb  = 24'd0;
   logic [23:0] rgb_out;
   logic        underflow;

   bg_mem_if #(.AW(AW)) mem ();

   bg_picture_mixer #(
      .AW         (AW),
      .FIFO_DEPTH (8),
      .PIC_PIXELS (PIC)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ce_pix    (ce_pix),
      .hblank    (hblank),
      .vblank    (vblank),
      .vs        (vs),
      .enable    (enable),
      .mode      (mode),
      .fg_rgb    (fg_rgb),
      .mem       (mem.master),
      .rgb_out   (rgb_out),
      .underflow (underflow)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Picture contents and memory model
   logic [31:0] pic [PIC];
   int          lat = 3;
   bit          pend = 0;
   int          cnt = 0;
   int          pend_idx = 0;
   int          req_idx = 0;

   initial begin
      mem.mem_ack  = 1'b0;
      mem.mem_dout = 32'd0;
      forever begin
         @(negedge clk_sys);
         mem.mem_ack = 1'b0;
         if (reset) begin
            pend = 0;
         end else begin
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  mem.mem_ack  = 1'b1;
                  mem.mem_dout = pic[pend_idx];
                  pend = 0;
               end
            end
            if (mem.mem_req) begin
               check("one_outstanding", {31'd0, pend}, 32'd0);
               check("req_addr", 32'(mem.mem_addr), 32'(2 * (req_idx % PIC)));
               pend_idx = int'(mem.mem_addr >> 1) % PIC;
               req_idx++;
               pend = 1;
               cnt  = lat;
            end
         end
      end
   end

   // Reference model: pixel k after a picture restart is pic[k mod PIC]
   typedef struct {
      logic [23:0] rgb;
      bit          care;
   } exp_t;

   exp_t sb_q[$];
   int   k = 0;

   function automatic logic [23:0] ref_mix(input logic [23:0] fg, input logic [31:0] px,
                                           input int md, input bit blk, input bit en,
                                           input bit have);
      int          a;
      int          ap;
      int          bv;
      int          fv;
      logic [23:0] bg;
      logic [23:0] res;
      res = 24'd0;
      if (blk) return 24'd0;
      if (!en || md == 0) return fg;
      a  = have ? int'(px[31:24]) : 0;
      bg = have ? {px[7:0], px[15:8], px[23:16]} : 24'd0;
      if (md == 3) return bg;
      if (md == 1) return (fg != 24'd0 && a == 0) ? fg : bg;
      ap = a + ((a >= 128) ? 1 : 0);
      for (int c = 0; c < 3; c++) begin
         bv = int'((bg >> (8 * c)) & 24'hFF);
         fv = int'((fg >> (8 * c)) & 24'hFF);
         res[8*c +: 8] = 8'((bv * ap + fv * (256 - ap)) / 256);
      end
      return res;
   endfunction

   task automatic pixel(input bit active, input logic [23:0] fg, input logic [1:0] md,
                        input int gap, input bit care, input bit empty_exp);
      exp_t        e;
      logic [31:0] px;
      bit          have;
      px     = 32'd0;
      have   = 0;
      ce_pix = 1'b1;
      hblank = !active;
      fg_rgb = fg;
      mode   = md;
      if (active && enable && !empty_exp) begin
         px   = pic[k % PIC];
         have = 1;
         k++;
      end
      e.rgb  = ref_mix(fg, px, int'(md), !active, enable, have);
      e.care = care;
      sb_q.push_back(e);
      @(posedge clk_sys); #1;
      ce_pix = 1'b0;
      repeat (gap - 1) begin
         @(posedge clk_sys); #1;
      end
   endtask

   task automatic restart();
      vs = 1'b1;
      pixel(0, 24'd0, 2'd3, 1, 1, 0);
      k       = 0;
      req_idx = 0;
      vs = 1'b0;
      pixel(0, 24'd0, 2'd3, 1, 1, 0);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_sys); #1;
      end
   endtask

   // Monitor: rgb_out is valid on the negedge after each ce_pix edge
   bit ce_seen = 0;
   always @(posedge clk_sys) ce_seen <= ce_pix;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk_sys);
         if (ce_seen) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underrun: output with no expected entry at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               if (e.care) check("rgb_out", {8'd0, rgb_out}, {8'd0, e.rgb});
            end
         end
      end
   end

   initial begin
      bit found;
      int active_cnt;
      for (int i = 0; i < PIC; i++) pic[i] = $urandom;
      pic[0] = 32'h00_12_34_56;
      pic[1] = 32'hFF_C0_B0_A0;
      pic[2] = 32'h80_00_FF_00;
      pic[3] = 32'h5A_11_22_33;
      pic[4] = 32'h00_44_55_66;
      pic[5] = 32'h01_77_88_99;

      // Reset state
      tick(3);
      check("rst_rgb", {8'd0, rgb_out}, 32'd0);
      check("rst_underflow", {31'd0, underflow}, 32'd0);
      check("rst_req", {31'd0, mem.mem_req}, 32'd0);
      check("rst_addr", 32'(mem.mem_addr), 32'd0);
      reset  = 1'b0;
      enable = 1'b1;
      mode   = 2'd3;

      // Reset while a request is outstanding
      found = 0;
      for (int t = 0; t < 50 && !found; t++) begin
         if (mem.mem_req) found = 1;
         else tick(1);
      end
      check("first_req_seen", {31'd0, found}, 32'd1);
      tick(1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_req", {31'd0, mem.mem_req}, 32'd0);
      check("async_rst_addr", 32'(mem.mem_addr), 32'd0);
      check("async_rst_count", 32'(dut.fifo_count), 32'd0);
      req_idx = 0;
      tick(2);
      reset = 1'b0;
      tick(120);
      check("fill_count", 32'(dut.fifo_count), 32'd8);
      check("fill_underflow", {31'd0, underflow}, 32'd0);

      // Alpha blend and colour key corner values
      restart();
      tick(120);
      pixel(1, 24'hFF0000, 2'd2, 8, 1, 0);
      pixel(1, 24'hFF0000, 2'd2, 8, 1, 0);
      pixel(1, 24'hFF0000, 2'd2, 8, 1, 0);
      pixel(1, 24'h000000, 2'd1, 8, 1, 0);
      pixel(1, 24'h010101, 2'd1, 8, 1, 0);
      pixel(1, 24'h010101, 2'd1, 8, 1, 0);

      // Random stream across the picture wrap
      active_cnt = 0;
      while (active_cnt < 20) begin
         bit act;
         act = ($urandom_range(0, 3) != 0);
         if (act) active_cnt++;
         pixel(act, 24'($urandom), 2'($urandom_range(0, 3)), 8, 1, 0);
      end
      check("stream_underflow", {31'd0, underflow}, 32'd0);

      // Slow memory: pixels popped from an empty FIFO
      lat = 20;
      restart();
      for (int i = 0; i < 4; i++) pixel(1, 24'($urandom), 2'd3, 2, 1, 1);
      check("underflow_set", {31'd0, underflow}, 32'd1);
      for (int i = 0; i < 16; i++) pixel(1, 24'($urandom), 2'd3, 2, 0, 0);
      check("underflow_sticky", {31'd0, underflow}, 32'd1);

      // Restart while a fetch of pixel 5 is in flight
      lat = 10;
      restart();
      check("restart_underflow_clr", {31'd0, underflow}, 32'd0);
      found = 0;
      for (int t = 0; t < 400 && !found; t++) begin
         if (mem.mem_req && mem.mem_addr == AW'(10)) found = 1;
         else tick(1);
      end
      check("req_p5_seen", {31'd0, found}, 32'd1);
      tick(3);
      restart();
      check("restart_count", 32'(dut.fifo_count), 32'd0);
      check("restart_underflow", {31'd0, underflow}, 32'd0);
      lat = 3;
      tick(150);
      check("refill_count", 32'(dut.fifo_count), 32'd8);
      for (int i = 0; i < 10; i++) pixel(1, 24'($urandom), 2'($urandom_range(0, 3)), 8, 1, 0);

      // Passthrough with the fetcher disabled
      enable = 1'b0;
      tick(30);
      check("disable_count", 32'(dut.fifo_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         pixel(1, 24'($urandom), 2'($urandom_range(0, 3)), 4, 1, 0);
         pixel(0, 24'($urandom), 2'($urandom_range(0, 3)), 4, 1, 0);
      end
      check("disable_underflow", {31'd0, underflow}, 32'd0);

      for (int t = 0; t < 20 && sb_q.size() != 0; t++) tick(1);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_drain: %0d outputs never appeared, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
